// File: rtl/de_hazard_unit.sv
// -----------------------------------------------------------------------------
// de_hazard_unit
//   Hazard/flush control on the consumer side of the decode/execute buffer.
//   Compares the instruction in EX (buffer outputs) with the one in decode
//   and produces stall, bubble and flush controls. It also produces the
//   FlashNum count that feeds the buffer's FlashNumIn, sequences two-word
//   (immediate) instructions and counts load-use stall cycles.
//
// Ports
//   Clk, Rst        clock; synchronous active-high reset
//   dec_src1/2      decode source register addresses
//   dec_use1/2      decode instruction actually reads src1/src2
//   dec_is_imm      decode instruction is two-word (next word is immediate)
//   ex_MR, ex_RW    EX-stage memory read / register write
//   ex_dest         EX-stage destination register
//   ex_br_taken     branch resolved taken in EX this cycle
//   pc_stall        hold PC
//   fd_stall        hold fetch/decode buffer
//   fd_flush        clear fetch/decode buffer
//   de_bubble       zero all control inputs of the decode/execute buffer
//   flush_num       remaining flush slots (to FlashNumIn)
//   imm_phase       fetched word is an immediate, not an opcode
//   stall_count     saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module de_hazard_unit #(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [2:0]       dec_src1,
    input  logic [2:0]       dec_src2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic             dec_is_imm,
    input  logic             ex_MR,
    input  logic             ex_RW,
    input  logic [2:0]       ex_dest,
    input  logic             ex_br_taken,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic [1:0]       flush_num,
    output logic             imm_phase,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMM   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Count loaded on a taken branch: the branch cycle itself is the first
    // squashed slot, so FLUSH covers the remaining FLUSH_DEPTH-1.
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_DEPTH - 1);

    state_t           state_q, state_d;
    logic [1:0]       flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    // Load-use: EX loads a register that decode reads. Register 0 is an
    // ordinary register here, so no zero-address exclusion.
    assign hazard = ex_MR & ex_RW &
                    ((dec_use1 & (dec_src1 == ex_dest)) |
                     (dec_use2 & (dec_src2 == ex_dest)));

    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        cnt_d     = cnt_q;
        pc_stall  = 1'b0;
        fd_stall  = 1'b0;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;

        if (ex_br_taken) begin
            // Taken branch wins over everything, in any state (aborts IMM,
            // reloads an in-progress FLUSH).
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                state_d = FLUSH;
                flush_d = FLUSH_INIT;
            end else begin
                state_d = RUN;
                flush_d = 2'd0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    flush_d = 2'd0;
                    if (hazard) begin
                        // One stall cycle; the bubble reaches EX next cycle
                        // and the compare naturally clears.
                        pc_stall  = 1'b1;
                        fd_stall  = 1'b1;
                        de_bubble = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}})
                            cnt_d = cnt_q + CNT_W'(1);
                    end else if (dec_is_imm) begin
                        state_d = IMM;
                    end
                end
                IMM: begin
                    // Immediate word must not execute as an opcode.
                    de_bubble = 1'b1;
                    state_d   = RUN;
                    flush_d   = 2'd0;
                end
                FLUSH: begin
                    de_bubble = 1'b1;
                    fd_flush  = 1'b1;
                    if (flush_q <= 2'd1) begin
                        state_d = RUN;
                        flush_d = 2'd0;
                    end else begin
                        flush_d = flush_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    flush_d = 2'd0;
                end
            endcase
        end
    end

    // imm_phase describes the fetched word, so it follows state alone.
    assign imm_phase   = (state_q == IMM);
    assign flush_num   = flush_q;
    assign stall_count = cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= RUN;
            flush_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_de_hazard_unit.sv
module tb_de_hazard_unit;

    typedef struct packed {
        logic [2:0] s1;
        logic [2:0] s2;
        logic       u1;
        logic       u2;
        logic       imm;
        logic       mr;
        logic       rw;
        logic [2:0] dst;
        logic       br;
    } in_t;

    typedef struct packed {
        logic       pc;
        logic       fs;
        logic       ff;
        logic       bb;
        logic [1:0] fn;
        logic       im;
        logic [3:0] cnt;
    } exp_t;

    typedef struct {
        exp_t  e;
        string name;
    } item_t;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [2:0] dec_src1, dec_src2, ex_dest;
    logic       dec_use1, dec_use2, dec_is_imm, ex_MR, ex_RW, ex_br_taken;
    logic       pc_stall, fd_stall, fd_flush, de_bubble, imm_phase;
    logic [1:0] flush_num;
    logic [3:0] stall_count;

    int n_chk  = 0;
    int n_pass = 0;
    item_t sb[$];

    always #5 Clk = ~Clk;

    de_hazard_unit #(.FLUSH_DEPTH(2), .CNT_W(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .dec_src1(dec_src1), .dec_src2(dec_src2),
        .dec_use1(dec_use1), .dec_use2(dec_use2),
        .dec_is_imm(dec_is_imm),
        .ex_MR(ex_MR), .ex_RW(ex_RW), .ex_dest(ex_dest),
        .ex_br_taken(ex_br_taken),
        .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
        .de_bubble(de_bubble), .flush_num(flush_num),
        .imm_phase(imm_phase), .stall_count(stall_count)
    );

    function automatic in_t I(logic [2:0] s1, logic [2:0] s2, logic u1, logic u2,
                              logic imm, logic mr, logic rw, logic [2:0] dst, logic br);
        in_t v;
        v = '{s1: s1, s2: s2, u1: u1, u2: u2, imm: imm, mr: mr, rw: rw, dst: dst, br: br};
        return v;
    endfunction

    function automatic exp_t E(logic pc, logic fs, logic ff, logic bb,
                               logic [1:0] fn, logic im, logic [3:0] cnt);
        exp_t e;
        e = '{pc: pc, fs: fs, ff: ff, bb: bb, fn: fn, im: im, cnt: cnt};
        return e;
    endfunction

    task automatic drive(in_t v);
        dec_src1 = v.s1; dec_src2 = v.s2; dec_use1 = v.u1; dec_use2 = v.u2;
        dec_is_imm = v.imm; ex_MR = v.mr; ex_RW = v.rw; ex_dest = v.dst;
        ex_br_taken = v.br;
    endtask

    // One reset cycle: no expectation pushed.
    task automatic rst_cycle(in_t v);
        @(posedge Clk); #1;
        Rst = 1'b1;
        drive(v);
    endtask

    // One functional cycle: drive inputs and queue the expected outputs.
    task automatic step(string nm, in_t v, exp_t e);
        item_t it;
        @(posedge Clk); #1;
        Rst = 1'b0;
        drive(v);
        it.e = e;
        it.name = nm;
        sb.push_back(it);
    endtask

    // Monitor: outputs are Mealy, so sample mid-cycle after inputs settle.
    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            item_t it;
            exp_t  act;
            it  = sb.pop_front();
            act = '{pc: pc_stall, fs: fd_stall, ff: fd_flush, bb: de_bubble,
                    fn: flush_num, im: imm_phase, cnt: stall_count};
            n_chk++;
            if (act === it.e) n_pass++;
            else $display("FAIL %s: got pc=%b fs=%b ff=%b bb=%b fn=%0d im=%b cnt=%0d, want pc=%b fs=%b ff=%b bb=%b fn=%0d im=%b cnt=%0d",
                          it.name, act.pc, act.fs, act.ff, act.bb, act.fn, act.im, act.cnt,
                          it.e.pc, it.e.fs, it.e.ff, it.e.bb, it.e.fn, it.e.im, it.e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t ID, HZ, BR;
        ID = I(0, 0, 0, 0, 0, 0, 0, 0, 0);
        HZ = I(0, 3, 0, 1, 0, 1, 1, 3, 0);
        BR = I(0, 0, 0, 0, 0, 0, 0, 0, 1);

        Rst = 1'b1;
        drive(I(3, 3, 1, 1, 1, 1, 1, 3, 1));
        rst_cycle(I(3, 3, 1, 1, 1, 1, 1, 3, 1));
        rst_cycle(I(3, 3, 1, 1, 1, 1, 1, 3, 1));

        step("reset_state",  ID, E(0,0,0,0,0,0,0));
        step("ld_use_src2",  HZ, E(1,1,0,1,0,0,0));
        step("after_stall",  ID, E(0,0,0,0,0,0,1));
        step("src2_unused",  I(0,3,0,0,0,1,1,3,0), E(0,0,0,0,0,0,1));
        step("ld_use_src1",  I(5,0,1,0,0,1,1,5,0), E(1,1,0,1,0,0,1));
        step("no_mem_read",  I(5,0,1,0,0,0,1,5,0), E(0,0,0,0,0,0,2));
        step("ld_use_reg0",  I(0,0,1,0,0,1,1,0,0), E(1,1,0,1,0,0,2));
        step("addr_differ",  I(4,0,1,0,0,1,1,0,0), E(0,0,0,0,0,0,3));

        step("br_cycle0",    BR, E(0,0,1,1,0,0,3));
        step("flush_hz_ign", HZ, E(0,0,1,1,1,0,3));
        step("flush_done",   ID, E(0,0,0,0,0,0,3));

        step("prio_all",     I(0,3,0,1,1,1,1,3,1), E(0,0,1,1,0,0,3));
        step("prio_flush",   ID, E(0,0,1,1,1,0,3));
        step("prio_run",     ID, E(0,0,0,0,0,0,3));

        step("br_reload0",   BR, E(0,0,1,1,0,0,3));
        step("br_in_flush",  BR, E(0,0,1,1,1,0,3));
        step("reloaded",     ID, E(0,0,1,1,1,0,3));
        step("reload_run",   ID, E(0,0,0,0,0,0,3));

        step("imm_issue",    I(0,0,0,0,1,0,0,0,0), E(0,0,0,0,0,0,3));
        step("imm_phase",    ID, E(0,0,0,1,0,1,3));
        step("imm_back_run", ID, E(0,0,0,0,0,0,3));

        step("imm_issue2",   I(0,0,0,0,1,0,0,0,0), E(0,0,0,0,0,0,3));
        step("imm_ign_hz",   I(0,3,0,1,1,1,1,3,0), E(0,0,0,1,0,1,3));
        step("imm_one_cyc",  ID, E(0,0,0,0,0,0,3));

        step("hz_over_imm",  I(0,3,0,1,1,1,1,3,0), E(1,1,0,1,0,0,3));
        step("no_imm_after", ID, E(0,0,0,0,0,0,4));

        step("imm_issue3",   I(0,0,0,0,1,0,0,0,0), E(0,0,0,0,0,0,4));
        step("br_in_imm",    BR, E(0,0,1,1,0,1,4));
        step("imm_to_flush", ID, E(0,0,1,1,1,0,4));
        step("imm_fl_run",   ID, E(0,0,0,0,0,0,4));

        for (int i = 0; i < 20; i++) begin
            step("sat_stall", HZ, E(1,1,0,1,0,0,((4 + i) > 15) ? 4'd15 : 4'(4 + i)));
        end
        step("sat_hold",     ID, E(0,0,0,0,0,0,15));

        step("br_pre_rst",   BR, E(0,0,1,1,0,0,15));
        rst_cycle(ID);
        step("rst_mid_flush", ID, E(0,0,0,0,0,0,0));

        step("imm_pre_rst",  I(0,0,0,0,1,0,0,0,0), E(0,0,0,0,0,0,0));
        rst_cycle(HZ);
        step("rst_mid_imm",  ID, E(0,0,0,0,0,0,0));

        @(negedge Clk); #1;
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
